// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared defines for the memory-access stage: op codes and lane helpers
package mem_access_pkg;

  localparam logic [4:0]  NOPRegAddr = 5'b00000;
  localparam logic [31:0] zeroword   = 32'h0000_0000;

  localparam logic [7:0] EXE_NOP_OP = 8'b0000_0000;
  localparam logic [7:0] EXE_ADD_OP = 8'b0010_0000;
  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  function automatic logic is_load(input logic [7:0] op);
    return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
  endfunction

  function automatic logic is_mem(input logic [7:0] op);
    return is_load(op) || is_store(op);
  endfunction

  function automatic logic misaligned(input logic [7:0] op, input logic [1:0] a);
    logic w_half;
    logic w_word;
    w_half = op inside {EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP};
    w_word = op inside {EXE_LW_OP, EXE_SW_OP};
    return (w_half && a[0]) || (w_word && (a != 2'b00));
  endfunction

  // Big-endian lanes: byte address 0 lives in bits 31:24.
  function automatic logic [3:0] store_sel(input logic [7:0] op, input logic [1:0] a);
    case (op)
      EXE_SB_OP: return 4'b1000 >> a;
      EXE_SH_OP: return a[1] ? 4'b0011 : 4'b1100;
      default:   return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [7:0] op, input logic [31:0] r2);
    case (op)
      EXE_SB_OP: return {4{r2[7:0]}};
      EXE_SH_OP: return {2{r2[15:0]}};
      default:   return r2;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - selects the addressed byte/halfword of a read word and extends it
module mem_load_align
  import mem_access_pkg::*;
(
  input  logic [7:0]  aluop_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] word_i,
  output logic [31:0] data_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (addr_lo_i)
      2'b00:   w_byte = word_i[31:24];
      2'b01:   w_byte = word_i[23:16];
      2'b10:   w_byte = word_i[15:8];
      default: w_byte = word_i[7:0];
    endcase
    w_half = addr_lo_i[1] ? word_i[15:0] : word_i[31:16];
    case (aluop_i)
      EXE_LB_OP:  data_o = {{24{w_byte[7]}}, w_byte};
      EXE_LBU_OP: data_o = {24'h000000, w_byte};
      EXE_LH_OP:  data_o = {{16{w_half[15]}}, w_half};
      EXE_LHU_OP: data_o = {16'h0000, w_half};
      default:    data_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM pipeline stage: drives the data bus and stalls until the access completes
module mem_access
  import mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        whilo_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        whilo_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  output logic        stallreq_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_cap;
  logic [7:0]  r_aluop;
  logic [31:0] r_addr;
  logic [31:0] r_reg2;

  logic        w_start;
  logic        w_drive;
  logic [7:0]  w_op;
  logic [31:0] w_addr;
  logic [31:0] w_reg2;
  logic [31:0] w_load_data;

  assign w_start = is_mem(aluop_i) && !misaligned(aluop_i, mem_addr_i[1:0]);

  // Outside IDLE the request is replayed from the snapshot so the bus sees stable values.
  assign w_op   = (r_state == ST_IDLE) ? aluop_i    : r_aluop;
  assign w_addr = (r_state == ST_IDLE) ? mem_addr_i : r_addr;
  assign w_reg2 = (r_state == ST_IDLE) ? reg2_i     : r_reg2;

  mem_load_align u_load_align (
    .aluop_i   (r_aluop),
    .addr_lo_i (r_addr[1:0]),
    .word_i    (r_cap),
    .data_o    (w_load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cap   <= zeroword;
      r_aluop <= EXE_NOP_OP;
      r_addr  <= zeroword;
      r_reg2  <= zeroword;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_aluop <= aluop_i;
          r_addr  <= mem_addr_i;
          r_reg2  <= reg2_i;
          if (w_start) begin
            r_state <= bus_ack_i ? ST_DONE : ST_BUSY;
            if (bus_ack_i && is_load(aluop_i)) r_cap <= bus_rdata_i;
          end
        end
        ST_BUSY: begin
          if (bus_ack_i) begin
            r_state <= ST_DONE;
            if (is_load(r_aluop)) r_cap <= bus_rdata_i;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    wd_o        = NOPRegAddr;
    wreg_o      = 1'b0;
    wdata_o     = zeroword;
    hi_o        = zeroword;
    lo_o        = zeroword;
    whilo_o     = 1'b0;
    bus_req_o   = 1'b0;
    bus_we_o    = 1'b0;
    bus_addr_o  = zeroword;
    bus_sel_o   = 4'b0000;
    bus_wdata_o = zeroword;
    stallreq_o  = 1'b0;
    misalign_o  = 1'b0;
    w_drive     = 1'b0;
    if (!rst) begin
      wd_o    = wd_i;
      wdata_o = wdata_i;
      hi_o    = hi_i;
      lo_o    = lo_i;
      case (r_state)
        ST_IDLE: begin
          if (!is_mem(aluop_i)) begin
            wreg_o  = wreg_i;
            whilo_o = whilo_i;
          end else if (!w_start) begin
            misalign_o = 1'b1;
          end else begin
            w_drive = 1'b1;
          end
        end
        ST_BUSY: w_drive = 1'b1;
        ST_DONE: begin
          wreg_o  = wreg_i && !is_store(r_aluop);
          whilo_o = whilo_i;
          if (is_load(r_aluop)) wdata_o = w_load_data;
        end
        default: ;
      endcase
      if (w_drive) begin
        bus_req_o   = 1'b1;
        stallreq_o  = 1'b1;
        bus_we_o    = is_store(w_op);
        bus_addr_o  = {w_addr[31:2], 2'b00};
        bus_sel_o   = is_store(w_op) ? store_sel(w_op, w_addr[1:0]) : 4'b1111;
        bus_wdata_o = store_data(w_op, w_reg2);
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - self-checking bench for mem_access against a behavioural model
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic [31:0] hi_i;
  logic [31:0] lo_i;
  logic        whilo_i;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i;
  logic [31:0] reg2_i;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        whilo_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_wdata_o;
  logic        stallreq_o;
  logic        misalign_o;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] STAGE_WDATA = 32'h5A5A_1234;

  int          ob_stalls;
  logic        ob_stable;
  logic        ob_timeout;
  logic [3:0]  ob_sel;
  logic [31:0] ob_bwdata;
  logic [31:0] ob_baddr;
  logic        ob_we;
  logic [31:0] ob_done_wdata;
  logic        ob_done_wreg;
  logic        ob_done_req;
  logic        ob_reissue;

  mem_access dut (
    .clk(clk), .rst(rst), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .hi_i(hi_i), .lo_i(lo_i), .whilo_i(whilo_i), .aluop_i(aluop_i),
    .mem_addr_i(mem_addr_i), .reg2_i(reg2_i), .bus_rdata_i(bus_rdata_i),
    .bus_ack_i(bus_ack_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .hi_o(hi_o), .lo_o(lo_o), .whilo_o(whilo_o), .bus_req_o(bus_req_o),
    .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_sel_o(bus_sel_o),
    .bus_wdata_o(bus_wdata_o), .stallreq_o(stallreq_o), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  function automatic logic m_is_load(input logic [7:0] op);
    return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
  endfunction

  function automatic logic m_is_store(input logic [7:0] op);
    return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
  endfunction

  // Reference: shift the addressed unit down arithmetically, then extend.
  function automatic logic [31:0] ref_load(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] word);
    int unsigned a;
    int unsigned v;
    a = addr % 4;
    case (op)
      EXE_LB_OP, EXE_LBU_OP: begin
        v = (word >> (8 * (3 - a))) & 32'hFF;
        if (op == EXE_LB_OP && v >= 128) v = v + 32'hFFFF_FF00;
      end
      EXE_LH_OP, EXE_LHU_OP: begin
        v = (word >> (16 * (1 - a / 2))) & 32'hFFFF;
        if (op == EXE_LH_OP && v >= 32768) v = v + 32'hFFFF_0000;
      end
      default: v = word;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] ref_sel(input logic [7:0] op, input logic [31:0] addr);
    int unsigned a;
    a = addr % 4;
    case (op)
      EXE_SB_OP: return 4'(1 << (3 - a));
      EXE_SH_OP: return 4'(3 << (2 - a));
      default:   return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [7:0] op, input logic [31:0] r2);
    case (op)
      EXE_SB_OP: return (r2 & 32'hFF) * 32'h0101_0101;
      EXE_SH_OP: return (r2 & 32'hFFFF) * 32'h0001_0001;
      default:   return r2;
    endcase
  endfunction

  // Drives one bus transaction with the given wait count, recording what the DUT showed.
  task automatic run_txn(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] r2,
                         input logic [31:0] rdata, input int waits);
    aluop_i = op; mem_addr_i = addr; reg2_i = r2;
    wreg_i = 1'b1; whilo_i = 1'b0; wd_i = 5'd9; wdata_i = STAGE_WDATA;
    bus_ack_i = 1'b0;
    ob_stalls = 0; ob_stable = 1'b1; ob_timeout = 1'b1;
    for (int c = 0; c < waits + 8; c++) begin
      #1;
      if (!stallreq_o) begin
        ob_timeout = 1'b0;
        break;
      end
      if (ob_stalls == 0) begin
        ob_sel = bus_sel_o; ob_bwdata = bus_wdata_o; ob_baddr = bus_addr_o; ob_we = bus_we_o;
      end else if (bus_sel_o !== ob_sel || bus_wdata_o !== ob_bwdata || bus_addr_o !== ob_baddr ||
                   bus_we_o !== ob_we || bus_req_o !== 1'b1) begin
        ob_stable = 1'b0;
      end
      bus_ack_i   = (ob_stalls == waits);
      bus_rdata_i = bus_ack_i ? rdata : $urandom;
      ob_stalls++;
      @(posedge clk); #1;
      bus_ack_i = 1'b0;
    end
    ob_done_wdata = wdata_o; ob_done_wreg = wreg_o; ob_done_req = bus_req_o;
    @(posedge clk); #1;
    ob_reissue = stallreq_o;
    aluop_i = EXE_NOP_OP;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    aluop_i = EXE_LW_OP; mem_addr_i = 32'h100; reg2_i = 32'h1; wreg_i = 1'b1; whilo_i = 1'b1;
    wd_i = 5'd7; wdata_i = 32'h1111; hi_i = 32'h2222; lo_i = 32'h3333;
    bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus_req_o, bus_we_o, stallreq_o, misalign_o, wreg_o, whilo_o} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=000000", {bus_req_o, bus_we_o, stallreq_o, misalign_o, wreg_o, whilo_o});
    end
    total++;
    if (wd_o !== 5'd0 || bus_sel_o !== 4'd0) begin
      bad++; $display("FAIL reset_wd_sel got=%h/%h exp=0/0", wd_o, bus_sel_o);
    end
    total++;
    if ({wdata_o, hi_o, lo_o} !== 96'd0) begin
      bad++; $display("FAIL reset_data got=%h %h %h exp=0", wdata_o, hi_o, lo_o);
    end
    rst = 1'b0;
    aluop_i = EXE_NOP_OP;
  endtask

  task automatic test_passthrough();
    for (int i = 0; i < 12; i++) begin
      logic [7:0] op;
      if (i == 0) op = EXE_ADD_OP;
      else do op = 8'($urandom); while (m_is_load(op) || m_is_store(op));
      aluop_i = op; wd_i = (i == 0) ? 5'd5 : 5'($urandom);
      wdata_i = (i == 0) ? 32'h1234_5678 : $urandom;
      wreg_i = (i == 0) ? 1'b1 : 1'($urandom); whilo_i = 1'($urandom);
      hi_i = $urandom; lo_i = $urandom; mem_addr_i = $urandom;
      bus_ack_i = 1'($urandom); bus_rdata_i = $urandom;
      #1;
      total++;
      if (wd_o !== wd_i || wreg_o !== wreg_i || wdata_o !== wdata_i || hi_o !== hi_i ||
          lo_o !== lo_i || whilo_o !== whilo_i) begin
        bad++; $display("FAIL pass_data op=%h got=%h/%b/%h exp=%h/%b/%h", op, wd_o, wreg_o, wdata_o, wd_i, wreg_i, wdata_i);
      end
      total++;
      if ({bus_req_o, stallreq_o, misalign_o} !== 3'b000) begin
        bad++; $display("FAIL pass_nobus op=%h got=%b exp=000", op, {bus_req_o, stallreq_o, misalign_o});
      end
      @(posedge clk); #1;
      total++;
      if (stallreq_o !== 1'b0) begin
        bad++; $display("FAIL pass_idle op=%h got=%b exp=0", op, stallreq_o);
      end
    end
    bus_ack_i = 1'b0;
    aluop_i = EXE_NOP_OP;
  endtask

  task automatic test_directed_load();
    run_txn(EXE_LB_OP, 32'h103, 32'h0, 32'h1122_33F0, 2);
    total++;
    if (ob_stalls != 3 || ob_timeout) begin
      bad++; $display("FAIL lb_stalls got=%0d exp=3", ob_stalls);
    end
    total++;
    if (ob_done_wdata !== 32'hFFFF_FFF0 || ob_done_wreg !== 1'b1) begin
      bad++; $display("FAIL lb_data got=%h/%b exp=fffffff0/1", ob_done_wdata, ob_done_wreg);
    end
    run_txn(EXE_LBU_OP, 32'h103, 32'h0, 32'h1122_33F0, 2);
    total++;
    if (ob_done_wdata !== 32'h0000_00F0) begin
      bad++; $display("FAIL lbu_data got=%h exp=000000f0", ob_done_wdata);
    end
  endtask

  task automatic test_store_sh();
    run_txn(EXE_SH_OP, 32'h202, 32'hAAAA_5555, 32'h0, 0);
    total++;
    if (ob_sel !== 4'b0011 || ob_bwdata !== 32'h5555_5555 || ob_we !== 1'b1) begin
      bad++; $display("FAIL sh_bus got=%b/%h/%b exp=0011/55555555/1", ob_sel, ob_bwdata, ob_we);
    end
    total++;
    if (ob_stalls != 1 || ob_done_wreg !== 1'b0) begin
      bad++; $display("FAIL sh_done got=%0d/%b exp=1/0", ob_stalls, ob_done_wreg);
    end
  endtask

  task automatic test_misalign();
    for (int i = 0; i < 8; i++) begin
      logic [7:0]  op;
      logic [31:0] addr;
      if (i == 0) begin
        op = EXE_LW_OP; addr = 32'h301;
      end else begin
        case ($urandom_range(0, 4))
          0: op = EXE_LH_OP;
          1: op = EXE_LHU_OP;
          2: op = EXE_SH_OP;
          3: op = EXE_LW_OP;
          default: op = EXE_SW_OP;
        endcase
        addr = $urandom;
        if (op == EXE_LW_OP || op == EXE_SW_OP) begin
          if (addr[1:0] == 2'b00) addr[0] = 1'b1;
        end else begin
          addr[0] = 1'b1;
        end
      end
      aluop_i = op; mem_addr_i = addr; wreg_i = 1'b1; whilo_i = 1'b1; bus_ack_i = 1'b0;
      #1;
      total++;
      if ({misalign_o, bus_req_o, stallreq_o, wreg_o, whilo_o} !== 5'b10000) begin
        bad++; $display("FAIL misalign op=%h addr=%h got=%b exp=10000", op, addr, {misalign_o, bus_req_o, stallreq_o, wreg_o, whilo_o});
      end
      @(posedge clk); #1;
      total++;
      if (stallreq_o !== 1'b0 || misalign_o !== 1'b1) begin
        bad++; $display("FAIL misalign_idle addr=%h got=%b%b exp=01", addr, stallreq_o, misalign_o);
      end
    end
    aluop_i = EXE_NOP_OP; whilo_i = 1'b0;
  endtask

  task automatic test_reset_busy();
    aluop_i = EXE_LW_OP; mem_addr_i = 32'h500; wreg_i = 1'b1; bus_ack_i = 1'b0;
    #1;
    @(posedge clk); #1;
    total++;
    if (stallreq_o !== 1'b1 || bus_req_o !== 1'b1) begin
      bad++; $display("FAIL rb_busy got=%b%b exp=11", stallreq_o, bus_req_o);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; aluop_i = EXE_NOP_OP; wd_i = 5'd3; wdata_i = 32'h77;
    bus_ack_i = 1'b1; bus_rdata_i = 32'hCAFE_BABE;
    #1;
    total++;
    if (stallreq_o !== 1'b0 || bus_req_o !== 1'b0 || wdata_o !== 32'h77) begin
      bad++; $display("FAIL rb_after got=%b%b/%h exp=00/00000077", stallreq_o, bus_req_o, wdata_o);
    end
    @(posedge clk); #1;
    bus_ack_i = 1'b0;
    total++;
    if (stallreq_o !== 1'b0 || wdata_o !== 32'h77 || wreg_o !== 1'b1) begin
      bad++; $display("FAIL rb_idle got=%b/%h/%b exp=0/00000077/1", stallreq_o, wdata_o, wreg_o);
    end
  endtask

  task automatic test_back_to_back();
    run_txn(EXE_SW_OP, 32'h400, 32'h0123_4567, 32'h0, 1);
    total++;
    if (ob_reissue !== 1'b1 || ob_done_req !== 1'b0 || ob_sel !== 4'hF || ob_bwdata !== 32'h0123_4567) begin
      bad++; $display("FAIL b2b_sw got=%b%b/%h/%h exp=10/f/01234567", ob_reissue, ob_done_req, ob_sel, ob_bwdata);
    end
    run_txn(EXE_LW_OP, 32'h400, 32'h0, 32'hDEAD_BEEF, 0);
    total++;
    if (ob_reissue !== 1'b1 || ob_done_req !== 1'b0 || ob_done_wdata !== 32'hDEAD_BEEF || ob_stalls != 1) begin
      bad++; $display("FAIL b2b_lw got=%b%b/%h/%0d exp=10/deadbeef/1", ob_reissue, ob_done_req, ob_done_wdata, ob_stalls);
    end
  endtask

  task automatic test_random_mem();
    logic [7:0] ops [8] = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP,
                            EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
    for (int i = 0; i < 24; i++) begin
      logic [7:0]  op;
      logic [31:0] addr;
      logic [31:0] r2;
      logic [31:0] rd;
      logic [31:0] exp_wdata;
      int          waits;
      op = ops[$urandom_range(0, 7)];
      addr = $urandom; r2 = $urandom; rd = $urandom; waits = $urandom_range(0, 3);
      if (op inside {EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP}) addr[0] = 1'b0;
      if (op inside {EXE_LW_OP, EXE_SW_OP}) addr[1:0] = 2'b00;
      run_txn(op, addr, r2, rd, waits);
      exp_wdata = m_is_load(op) ? ref_load(op, addr, rd) : STAGE_WDATA;
      total++;
      if (ob_timeout || ob_stalls != waits + 1 || !ob_stable) begin
        bad++; $display("FAIL rnd_stall op=%h got=%0d/%b exp=%0d/1", op, ob_stalls, ob_stable, waits + 1);
      end
      total++;
      if (ob_sel !== ref_sel(op, addr) || ob_we !== m_is_store(op) || ob_baddr !== (addr & 32'hFFFF_FFFC)) begin
        bad++; $display("FAIL rnd_bus op=%h addr=%h got=%b/%b/%h exp=%b/%b/%h", op, addr, ob_sel, ob_we, ob_baddr,
                        ref_sel(op, addr), m_is_store(op), addr & 32'hFFFF_FFFC);
      end
      if (m_is_store(op)) begin
        total++;
        if (ob_bwdata !== ref_wdata(op, r2)) begin
          bad++; $display("FAIL rnd_stdata op=%h got=%h exp=%h", op, ob_bwdata, ref_wdata(op, r2));
        end
      end
      total++;
      if (ob_done_wdata !== exp_wdata || ob_done_wreg !== m_is_load(op) || ob_done_req !== 1'b0 || ob_reissue !== 1'b1) begin
        bad++; $display("FAIL rnd_done op=%h addr=%h got=%h/%b/%b/%b exp=%h/%b/0/1", op, addr, ob_done_wdata,
                        ob_done_wreg, ob_done_req, ob_reissue, exp_wdata, m_is_load(op));
      end
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_directed_load();
    test_store_sh();
    test_misalign();
    test_reset_busy();
    test_back_to_back();
    test_random_mem();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
